// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store front end for a 256 x 32-bit word RAM with byte addressing.
// Supports byte, halfword and word loads (sign- or zero-extended) and
// stores. Sub-word stores use a read-modify-write sequence. Misaligned
// accesses and the reserved size are rejected with an error response.
//
// Ports
//   Clk        in   1   clock, all state changes on rising edge
//   Reset      in   1   synchronous active-high reset
//   ReqValid   in   1   request present
//   ReqReady   out  1   unit idle, request accepted on ReqValid&ReqReady
//   ReqWrite   in   1   1 = store, 0 = load
//   ReqSize    in   2   00 byte, 01 half, 10 word, 11 reserved
//   ReqSigned  in   1   load extension: 1 = sign, 0 = zero
//   ReqAddr    in  10   byte address (word = [9:2], lane = [1:0])
//   ReqData    in  32   right-aligned store data
//   RespValid  out  1   response present
//   RespReady  in   1   response taken on RespValid&RespReady
//   RespData   out 32   extended load data, 0 for stores and errors
//   RespErr    out  1   request rejected
//   InSel      out  8   RAM write word address
//   In         out 32   RAM write data
//   WrEn       out  1   RAM write strobe
//   OutSel     out  8   RAM read word address
//   Out        in  32   RAM read data (combinational from OutSel)
module mem_access_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [9:0]  ReqAddr,
  input  logic [31:0] ReqData,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespData,
  output logic        RespErr,
  output logic [7:0]  InSel,
  output logic [31:0] In,
  output logic        WrEn,
  output logic [7:0]  OutSel,
  input  logic [31:0] Out
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        write_q, write_d;
  logic [31:0] data_q, data_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        req_bad;
  logic [3:0]  lane_we;
  logic [31:0] store_rep;
  logic [31:0] merged;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  // Alignment / size check on the live request, evaluated at accept.
  always_comb begin
    req_bad = 1'b0;
    if (ReqSize == 2'b11)                            req_bad = 1'b1;
    else if (ReqSize == SZ_HALF && ReqAddr[0])       req_bad = 1'b1;
    else if (ReqSize == SZ_WORD && ReqAddr[1:0] != 2'b00) req_bad = 1'b1;
  end

  // Byte-lane write enables for the merge in a read-modify-write.
  always_comb begin
    lane_we = 4'b0000;
    case (size_q)
      SZ_BYTE: lane_we[addr_q[1:0]] = 1'b1;
      SZ_HALF: lane_we = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_we = 4'b1111;
    endcase
  end

  // Replicating the right-aligned store data puts it in every lane it
  // could land in, so the merge is a simple per-lane select.
  always_comb begin
    case (size_q)
      SZ_BYTE: store_rep = {4{data_q[7:0]}};
      SZ_HALF: store_rep = {2{data_q[15:0]}};
      default: store_rep = data_q;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[8*gi +: 8] = lane_we[gi] ? store_rep[8*gi +: 8] : Out[8*gi +: 8];
    end
  endgenerate

  // Lane extraction and extension for loads.
  always_comb begin
    load_byte = Out[8*addr_q[1:0] +: 8];
    load_half = addr_q[1] ? Out[31:16] : Out[15:0];
    case (size_q)
      SZ_BYTE: load_ext = {{24{signed_q & load_byte[7]}}, load_byte};
      SZ_HALF: load_ext = {{16{signed_q & load_half[15]}}, load_half};
      default: load_ext = Out;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    signed_d    = signed_q;
    write_d     = write_q;
    data_d      = data_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          addr_d      = ReqAddr;
          size_d      = ReqSize;
          signed_d    = ReqSigned;
          write_d     = ReqWrite;
          data_d      = ReqData;
          resp_data_d = 32'h0;
          resp_err_d  = 1'b0;
          if (req_bad) begin
            resp_err_d = 1'b1;
            state_d    = RESP;
          end else if (ReqWrite && ReqSize == SZ_WORD) begin
            wdata_d = ReqData;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (write_q) begin
          wdata_d = merged;
          state_d = WRITE;
        end else begin
          resp_data_d = load_ext;
          state_d     = RESP;
        end
      end
      WRITE: state_d = RESP;
      RESP:  if (RespReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      write_q     <= 1'b0;
      data_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      write_q     <= write_d;
      data_q      <= data_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // All outputs decode from registered state only.
  assign ReqReady  = (state_q == IDLE);
  assign RespValid = (state_q == RESP);
  assign RespData  = (state_q == RESP) ? resp_data_q : 32'h0;
  assign RespErr   = (state_q == RESP) & resp_err_q;
  assign OutSel    = (state_q == READ) ? addr_q[9:2] : 8'h0;
  assign WrEn      = (state_q == WRITE);
  assign InSel     = (state_q == WRITE) ? addr_q[9:2] : 8'h0;
  assign In        = (state_q == WRITE) ? wdata_q : 32'h0;

endmodule
